// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch-to-decode path: packet layout, opcodes, fetch FSM states.
package fetch_stage_pkg;

    localparam int unsigned FETCH_PC_W   = 64;
    localparam int unsigned FETCH_INSN_W = 32;
    localparam int unsigned FETCH_MASK_W = 8;
    localparam int unsigned OPCODE_W     = 8;
    localparam int unsigned INSN_BYTES   = 4;

    typedef enum logic [OPCODE_W-1:0] {
        INSN_OPCODE_NOP  = 8'h00,
        INSN_OPCODE_JMP  = 8'h01,
        INSN_OPCODE_ADD  = 8'h03,
        INSN_OPCODE_HALT = 8'hFF
    } opcode_t;

    typedef struct packed {
        logic [FETCH_MASK_W-1:0] exec_mask;
        logic [FETCH_PC_W-1:0]   pc;
        logic [FETCH_INSN_W-1:0] insn;
    } fetch_to_decode_bus_packet_t;

    typedef enum logic [1:0] {
        REQ,
        WAIT_RSP,
        SEND,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-side bundle: instruction-memory read port, decode packet port, execute redirect.
interface fetch_stage_if #(
    parameter int unsigned PC_W   = 64,
    parameter int unsigned INSN_W = 32,
    parameter int unsigned MASK_W = 8
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [PC_W-1:0]   mem_req_addr;
    logic              mem_rsp_valid;
    logic [INSN_W-1:0] mem_rsp_data;

    logic              dec_valid;
    logic              dec_ready;
    logic [PC_W-1:0]   dec_pc;
    logic [INSN_W-1:0] dec_insn;
    logic [MASK_W-1:0] dec_exec_mask;

    logic              redir_valid;
    logic [PC_W-1:0]   redir_pc;
    logic [MASK_W-1:0] redir_mask;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output dec_valid, dec_pc, dec_insn, dec_exec_mask,
        input  dec_ready,
        input  redir_valid, redir_pc, redir_mask
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  dec_valid, dec_pc, dec_insn, dec_exec_mask,
        output dec_ready,
        output redir_valid, redir_pc, redir_mask
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: walks the PC with one outstanding memory read and hands
// {exec_mask, pc, insn} packets to decode; redirects win over everything.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned    CORE_ID  = 0,
    parameter int unsigned    PC_W     = FETCH_PC_W,
    parameter int unsigned    INSN_W   = FETCH_INSN_W,
    parameter int unsigned    MASK_W   = FETCH_MASK_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus,
    output logic          halted,
    output logic [31:0]   fetch_count
);

    if (PC_W < 3 || INSN_W < OPCODE_W || MASK_W == 0) begin : g_bad_cfg
        $error("fetch_stage core %0d: unsupported width configuration", CORE_ID);
    end

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, inflight_pc_q;
    logic [MASK_W-1:0] mask_q;
    logic              squash_q;
    logic [PC_W-1:0]   dec_pc_q;
    logic [INSN_W-1:0] dec_insn_q;
    logic [MASK_W-1:0] dec_mask_q;
    logic              halted_q;
    logic [31:0]       fetch_count_q;

    logic req_valid, pkt_valid;
    logic req_fire, rsp_take, xfer, enter_halt, squash_set, squash_clr;
    logic is_halt;

    assign is_halt = (dec_insn_q[OPCODE_W-1:0] == OPCODE_W'(INSN_OPCODE_HALT));

    // Next-state and handshake strobes; redirect is checked first in every state.
    always_comb begin
        state_d    = state_q;
        req_valid  = 1'b0;
        pkt_valid  = 1'b0;
        req_fire   = 1'b0;
        rsp_take   = 1'b0;
        xfer       = 1'b0;
        enter_halt = 1'b0;
        squash_set = 1'b0;
        squash_clr = 1'b0;
        unique case (state_q)
            REQ: begin
                req_valid = rst_n && !bus.redir_valid;
                if (req_valid && bus.mem_req_ready) begin
                    req_fire = 1'b1;
                    state_d  = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (bus.mem_rsp_valid) begin
                    squash_clr = 1'b1;
                    if (bus.redir_valid || squash_q) begin
                        state_d = REQ;
                    end else begin
                        rsp_take = 1'b1;
                        state_d  = SEND;
                    end
                end else if (bus.redir_valid) begin
                    squash_set = 1'b1;
                end
            end
            SEND: begin
                pkt_valid = !bus.redir_valid;
                if (bus.redir_valid) begin
                    state_d = REQ;
                end else if (bus.dec_ready) begin
                    xfer       = 1'b1;
                    enter_halt = is_halt;
                    state_d    = is_halt ? HALTED : REQ;
                end
            end
            HALTED: begin
                if (bus.redir_valid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= REQ;
        else        state_q <= state_d;
    end

    // PC/mask tracking, squash flag, packet register and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            mask_q        <= '1;
            squash_q      <= 1'b0;
            dec_pc_q      <= '0;
            dec_insn_q    <= '0;
            dec_mask_q    <= '0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            if (squash_set)      squash_q <= 1'b1;
            else if (squash_clr) squash_q <= 1'b0;

            if (req_fire) inflight_pc_q <= pc_q;

            if (bus.redir_valid) begin
                pc_q   <= bus.redir_pc;
                mask_q <= bus.redir_mask;
            end else if (rsp_take) begin
                pc_q <= inflight_pc_q + PC_W'(INSN_BYTES);
            end

            if (rsp_take) begin
                dec_pc_q   <= inflight_pc_q;
                dec_insn_q <= bus.mem_rsp_data;
                dec_mask_q <= mask_q;
            end

            if (xfer) fetch_count_q <= fetch_count_q + 32'd1;

            if (bus.redir_valid) halted_q <= 1'b0;
            else if (enter_halt) halted_q <= 1'b1;
        end
    end

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = pc_q;
    assign bus.dec_valid     = pkt_valid;
    assign bus.dec_pc        = dec_pc_q;
    assign bus.dec_insn      = dec_insn_q;
    assign bus.dec_exec_mask = dec_mask_q;
    assign halted            = halted_q;
    assign fetch_count       = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: small latency-programmable memory model,
// transfer/request monitor, hand-computed expectations.
module tb_fetch_stage;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSN_W  = 32;
    localparam int unsigned MASK_W  = 8;
    localparam int unsigned CORE_ID = 0;
    localparam logic [31:0] WORD_ADD  = 32'h1234_5603;
    localparam logic [31:0] WORD_HALT = 32'h0000_00FF;
    localparam logic [31:0] WORD_ALU  = 32'h0000_0011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halted;
    logic [31:0] fetch_count;

    fetch_stage_if #(.PC_W(PC_W), .INSN_W(INSN_W), .MASK_W(MASK_W)) bus ();

    fetch_stage #(
        .CORE_ID (CORE_ID),
        .PC_W    (PC_W),
        .INSN_W  (INSN_W),
        .MASK_W  (MASK_W),
        .RESET_PC(64'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.master),
        .halted     (halted),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h8:   return WORD_ADD;
            64'h20:  return WORD_HALT;
            64'h100: return WORD_ALU;
            default: return 32'h0;
        endcase
    endfunction

    // Memory model: response arrives `lat` cycles after acceptance, one outstanding
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [63:0] pend_addr = '0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;

    assign bus.mem_rsp_valid = rsp_valid;
    assign bus.mem_rsp_data  = rsp_data;

    always @(posedge clk) begin
        rsp_valid <= 1'b0;
        if (pend) begin
            if (cnt == 1) begin
                rsp_valid <= 1'b1;
                rsp_data  <= mem_word(pend_addr);
                pend      <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            if (lat <= 1) begin
                rsp_valid <= 1'b1;
                rsp_data  <= mem_word(bus.mem_req_addr);
            end else begin
                pend      <= 1'b1;
                cnt       <= lat - 1;
                pend_addr <= bus.mem_req_addr;
            end
        end
    end

    // Monitor: decode transfers, accepted requests, valid-cycle counters
    int          cyc = 0, xfer_n = 0, req_n = 0, dv_n = 0, rv_n = 0;
    logic [63:0] x_pc   [64];
    logic [31:0] x_insn [64];
    logic [7:0]  x_mask [64];
    int          x_cyc  [64];
    logic [63:0] r_addr [64];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (bus.dec_valid && bus.dec_ready && xfer_n < 64) begin
                x_pc[xfer_n]   = bus.dec_pc;
                x_insn[xfer_n] = bus.dec_insn;
                x_mask[xfer_n] = bus.dec_exec_mask;
                x_cyc[xfer_n]  = cyc;
                xfer_n         = xfer_n + 1;
                $display("[FETCH] core %0d, PC 0x%0h, opcode 0x%02h", CORE_ID, bus.dec_pc, bus.dec_insn[7:0]);
            end
            if (bus.mem_req_valid && bus.mem_req_ready && req_n < 64) begin
                r_addr[req_n] = bus.mem_req_addr;
                req_n         = req_n + 1;
            end
            if (bus.dec_valid)     dv_n = dv_n + 1;
            if (bus.mem_req_valid) rv_n = rv_n + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_xfers(input int n);
        for (int i = 0; i < 100 && xfer_n < n; i++) @(negedge clk);
    endtask

    task automatic wait_reqs(input int n);
        for (int i = 0; i < 100 && req_n < n; i++) @(negedge clk);
    endtask

    task automatic wait_dec_valid();
        for (int i = 0; i < 100 && !bus.dec_valid; i++) @(negedge clk);
    endtask

    task automatic redirect(input logic [63:0] pc, input logic [7:0] m);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = pc;
        bus.redir_mask  = m;
        @(negedge clk);
        bus.redir_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int   rq, dv, rv, xn;
        logic stable;

        rst_n             = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.dec_ready     = 1'b1;
        bus.redir_valid   = 1'b0;
        bus.redir_pc      = '0;
        bus.redir_mask    = '0;
        repeat (3) @(negedge clk);

        check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("rst_dec_valid",     64'(bus.dec_valid),     64'd0);
        check("rst_dec_pc",        bus.dec_pc,             64'd0);
        check("rst_dec_mask",      64'(bus.dec_exec_mask), 64'd0);
        check("rst_halted",        64'(halted),            64'd0);
        check("rst_fetch_count",   64'(fetch_count),       64'd0);
        rst_n = 1'b1;

        // Back-to-back NOPs at 0x0 and 0x4
        wait_xfers(2);
        bus.dec_ready = 1'b0;
        check("t1_xfers",   64'(xfer_n), 64'd2);
        check("t1_pc0",     x_pc[0],     64'h0);
        check("t1_pc1",     x_pc[1],     64'h4);
        check("t1_spacing", 64'(x_cyc[1] - x_cyc[0]), 64'd3);
        check("t1_mask0",   64'(x_mask[0]), 64'hFF);
        check("t1_mask1",   64'(x_mask[1]), 64'hFF);
        check("t1_fc",      64'(fetch_count), 64'd2);

        // Decode stall holding 0x12345603 at 0x8
        wait_dec_valid();
        check("t2_dec_valid", 64'(bus.dec_valid), 64'd1);
        check("t2_dec_pc",    bus.dec_pc,         64'h8);
        check("t2_dec_insn",  64'(bus.dec_insn),  64'(WORD_ADD));
        rq     = req_n;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!(bus.dec_valid && bus.dec_pc == 64'h8 && bus.dec_insn == WORD_ADD &&
                  bus.dec_exec_mask == 8'hFF)) stable = 1'b0;
        end
        check("t2_stable", 64'(stable), 64'd1);
        check("t2_no_req", 64'(req_n), 64'(rq));
        check("t2_fc",     64'(fetch_count), 64'd2);
        lat           = 3;
        bus.dec_ready = 1'b1;
        wait_reqs(rq + 1);
        check("t2_xfers",     64'(xfer_n), 64'd3);
        check("t2_xfer_pc",   x_pc[2],     64'h8);
        check("t2_next_addr", r_addr[rq],  64'hC);

        // Redirect while waiting; late response must be dropped
        dv = dv_n;
        redirect(64'h100, 8'h0F);
        lat = 1;
        wait_reqs(rq + 2);
        check("t3_addr",        r_addr[rq + 1], 64'h100);
        check("t3_no_dec_valid", 64'(dv_n), 64'(dv));
        wait_xfers(4);
        bus.dec_ready = 1'b0;
        check("t3_pc",   x_pc[3],          64'h100);
        check("t3_mask", 64'(x_mask[3]),   64'h0F);
        check("t3_insn", 64'(x_insn[3]),   64'(WORD_ALU));

        // Redirect and dec_ready in the same SEND cycle
        wait_dec_valid();
        check("t4_held_pc", bus.dec_pc, 64'h104);
        bus.dec_ready   = 1'b1;
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 64'h20;
        bus.redir_mask  = 8'hFF;
        #1;
        check("t4_dec_valid_low", 64'(bus.dec_valid), 64'd0);
        @(negedge clk);
        bus.redir_valid = 1'b0;
        check("t4_fc",    64'(fetch_count), 64'd4);
        check("t4_xfers", 64'(xfer_n),      64'd4);
        rq = req_n;
        wait_reqs(rq + 1);
        check("t4_addr", r_addr[rq], 64'h20);

        // HALT parks the stage until a redirect
        for (int i = 0; i < 50 && !halted; i++) @(negedge clk);
        check("t5_halted",  64'(halted),      64'd1);
        check("t5_pc",      x_pc[4],          64'h20);
        check("t5_insn",    64'(x_insn[4]),   64'(WORD_HALT));
        check("t5_fc",      64'(fetch_count), 64'd5);
        rv = rv_n;
        repeat (20) @(negedge clk);
        check("t5_no_req",  64'(rv_n),   64'(rv));
        check("t5_parked",  64'(halted), 64'd1);
        rq = req_n;
        redirect(64'h40, 8'hFF);
        bus.dec_ready = 1'b0;
        check("t5_unhalt", 64'(halted), 64'd0);
        wait_reqs(rq + 1);
        check("t5_addr", r_addr[rq], 64'h40);

        // Reset in the middle of a read at 0x30
        wait_dec_valid();
        check("t6_held_pc", bus.dec_pc, 64'h40);
        lat = 3;
        rq  = req_n;
        redirect(64'h30, 8'hFF);
        wait_reqs(rq + 1);
        check("t6_addr", r_addr[rq], 64'h30);
        rst_n             = 1'b0;
        bus.mem_req_ready = 1'b0;
        #1;
        check("t6_rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("t6_rst_dec_valid", 64'(bus.dec_valid),     64'd0);
        check("t6_rst_dec_pc",    bus.dec_pc,             64'd0);
        check("t6_rst_dec_insn",  64'(bus.dec_insn),      64'd0);
        check("t6_rst_dec_mask",  64'(bus.dec_exec_mask), 64'd0);
        check("t6_rst_fc",        64'(fetch_count),       64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        dv     = dv_n;
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (!(bus.mem_req_valid && bus.mem_req_addr == 64'h0)) stable = 1'b0;
        end
        check("t6_req_held",     64'(stable), 64'd1);
        check("t6_late_ignored", 64'(dv_n),   64'(dv));
        rq                = req_n;
        xn                = xfer_n;
        lat               = 1;
        bus.mem_req_ready = 1'b1;
        bus.dec_ready     = 1'b1;
        wait_xfers(xn + 1);
        check("t6_first_addr", r_addr[rq],      64'h0);
        check("t6_pc",         x_pc[xn],        64'h0);
        check("t6_mask",       64'(x_mask[xn]), 64'hFF);
        check("t6_fc",         64'(fetch_count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
